// File: rtl/dcache_responder.sv
// Memory-stage data-cache responder: direct-mapped, write-through, no-write-allocate
// cache of 64-bit words, backed by a valid/ready memory request channel.
module dcache_responder #(
    parameter int unsigned LINES  = 16,
    parameter int unsigned ADDR_W = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [63:0]       write_data,
    input  logic              read_enable,
    input  logic              write_enable,
    input  logic [7:0]        byte_enable,
    output logic              req_ready,
    output logic [63:0]       read_data,
    output logic              data_valid,
    output logic              cache_result,
    output logic              write_complete,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_write,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [63:0]       mem_req_wdata,
    output logic [7:0]        mem_req_wstrb,
    input  logic              mem_resp_valid,
    input  logic [63:0]       mem_resp_rdata
);

    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = ADDR_W - 3 - IDX_W;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4,
        DONE    = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [63:0]         wdata_q, wdata_d;
    logic [7:0]          wstrb_q, wstrb_d;
    logic [63:0]         read_data_q, read_data_d;
    logic                data_valid_q, data_valid_d;
    logic                cache_result_q, cache_result_d;
    logic                write_complete_q, write_complete_d;
    logic                req_ready_q, req_ready_d;
    logic                mem_req_valid_q, mem_req_valid_d;
    logic                mem_req_write_q, mem_req_write_d;
    logic [LINES-1:0]    valid_q, valid_d;

    logic [TAG_W-1:0]    tag_mem  [LINES];
    logic [63:0]         data_mem [LINES];

    logic [IDX_W-1:0]    in_idx_c, q_idx_c;
    logic [TAG_W-1:0]    in_tag_c, q_tag_c;
    logic                in_hit_c, q_hit_c;
    logic [63:0]         merged_c;
    logic                fill_en_c, merge_en_c;
    logic                unused_lsb_c;

    assign unused_lsb_c = ^address[2:0];

    // Lookup for an incoming request (IDLE) and for the latched request (store merge).
    assign in_idx_c = address[3 +: IDX_W];
    assign in_tag_c = address[ADDR_W-1 -: TAG_W];
    assign q_idx_c  = addr_q[3 +: IDX_W];
    assign q_tag_c  = addr_q[ADDR_W-1 -: TAG_W];
    assign in_hit_c = valid_q[in_idx_c] && (tag_mem[in_idx_c] == in_tag_c);
    assign q_hit_c  = valid_q[q_idx_c] && (tag_mem[q_idx_c] == q_tag_c);

    always_comb begin
        merged_c = data_mem[q_idx_c];
        for (int b = 0; b < 8; b++) begin
            if (wstrb_q[b]) merged_c[8*b +: 8] = wdata_q[8*b +: 8];
        end
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        wstrb_d          = wstrb_q;
        read_data_d      = read_data_q;
        data_valid_d     = 1'b0;
        cache_result_d   = cache_result_q;
        write_complete_d = 1'b0;
        valid_d          = valid_q;
        fill_en_c        = 1'b0;
        merge_en_c       = 1'b0;

        case (state_q)
            IDLE: begin
                if (write_enable) begin
                    addr_d  = {address[ADDR_W-1:3], 3'b000};
                    wdata_d = write_data;
                    wstrb_d = byte_enable;
                    state_d = WR_REQ;
                end else if (read_enable) begin
                    addr_d = {address[ADDR_W-1:3], 3'b000};
                    if (in_hit_c) begin
                        read_data_d    = data_mem[in_idx_c];
                        cache_result_d = 1'b1;
                        data_valid_d   = 1'b1;
                        state_d        = DONE;
                    end else begin
                        state_d = RD_REQ;
                    end
                end
            end
            RD_REQ:  if (mem_req_ready) state_d = RD_WAIT;
            RD_WAIT: begin
                if (mem_resp_valid) begin
                    fill_en_c          = 1'b1;
                    valid_d[q_idx_c]   = 1'b1;
                    read_data_d        = mem_resp_rdata;
                    cache_result_d     = 1'b0;
                    data_valid_d       = 1'b1;
                    state_d            = DONE;
                end
            end
            WR_REQ:  if (mem_req_ready) state_d = WR_WAIT;
            WR_WAIT: begin
                if (mem_resp_valid) begin
                    write_complete_d = 1'b1;
                    merge_en_c       = q_hit_c;
                    state_d          = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        req_ready_d     = (state_d == IDLE);
        mem_req_valid_d = (state_d == RD_REQ) || (state_d == WR_REQ);
        mem_req_write_d = (state_d == WR_REQ);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q          <= IDLE;
            addr_q           <= '0;
            wdata_q          <= '0;
            wstrb_q          <= '0;
            read_data_q      <= '0;
            data_valid_q     <= 1'b0;
            cache_result_q   <= 1'b0;
            write_complete_q <= 1'b0;
            req_ready_q      <= 1'b1;
            mem_req_valid_q  <= 1'b0;
            mem_req_write_q  <= 1'b0;
            valid_q          <= '0;
        end else begin
            state_q          <= state_d;
            addr_q           <= addr_d;
            wdata_q          <= wdata_d;
            wstrb_q          <= wstrb_d;
            read_data_q      <= read_data_d;
            data_valid_q     <= data_valid_d;
            cache_result_q   <= cache_result_d;
            write_complete_q <= write_complete_d;
            req_ready_q      <= req_ready_d;
            mem_req_valid_q  <= mem_req_valid_d;
            mem_req_write_q  <= mem_req_write_d;
            valid_q          <= valid_d;
        end
    end

    // Tag/data storage needs no reset; the valid bits gate every use.
    always_ff @(posedge clock) begin
        if (fill_en_c) begin
            tag_mem[q_idx_c]  <= q_tag_c;
            data_mem[q_idx_c] <= mem_resp_rdata;
        end else if (merge_en_c) begin
            data_mem[q_idx_c] <= merged_c;
        end
    end

    assign req_ready      = req_ready_q;
    assign read_data      = read_data_q;
    assign data_valid     = data_valid_q;
    assign cache_result   = cache_result_q;
    assign write_complete = write_complete_q;
    assign mem_req_valid  = mem_req_valid_q;
    assign mem_req_write  = mem_req_write_q;
    assign mem_req_addr   = addr_q;
    assign mem_req_wdata  = wdata_q;
    assign mem_req_wstrb  = wstrb_q;

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder: miss/hit, store merge, no-allocate,
// conflict eviction with backpressure, and reset during an outstanding miss.
module tb_dcache_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic [63:0] address;
    logic [63:0] write_data;
    logic        read_enable;
    logic        write_enable;
    logic [7:0]  byte_enable;
    logic        req_ready;
    logic [63:0] read_data;
    logic        data_valid;
    logic        cache_result;
    logic        write_complete;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_write;
    logic [63:0] mem_req_addr;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wstrb;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int rd_hs    = 0;
    int wr_hs    = 0;

    dcache_responder #(.LINES(16), .ADDR_W(64)) dut (
        .clock          (clock),
        .reset          (reset),
        .address        (address),
        .write_data     (write_data),
        .read_enable    (read_enable),
        .write_enable   (write_enable),
        .byte_enable    (byte_enable),
        .req_ready      (req_ready),
        .read_data      (read_data),
        .data_valid     (data_valid),
        .cache_result   (cache_result),
        .write_complete (write_complete),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_write  (mem_req_write),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wstrb  (mem_req_wstrb),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata)
    );

    always #5 clock = ~clock;

    // Count memory-channel handshakes seen at the clock edge.
    always @(posedge clock) begin
        if (mem_req_valid && mem_req_ready) begin
            if (mem_req_write) wr_hs <= wr_hs + 1;
            else               rd_hs <= rd_hs + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [63:0] a);
        address     = a;
        read_enable = 1'b1;
        tick();
        read_enable = 1'b0;
    endtask

    task automatic store(input logic [63:0] a, input logic [63:0] d, input logic [7:0] be);
        address      = a;
        write_data   = d;
        byte_enable  = be;
        write_enable = 1'b1;
        tick();
        write_enable = 1'b0;
    endtask

    task automatic respond(input logic [63:0] d);
        mem_resp_valid = 1'b1;
        mem_resp_rdata = d;
        tick();
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
    endtask

    initial begin
        reset          = 1'b0;
        address        = '0;
        write_data     = '0;
        read_enable    = 1'b0;
        write_enable   = 1'b0;
        byte_enable    = '0;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        tick();
        tick();
        reset = 1'b1;
        tick();

        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_read_data", read_data, 64'd0);
        check("rst_outputs", 64'({data_valid, cache_result, write_complete, mem_req_valid}), 64'd0);

        // 1: cold load miss
        load(64'h1008);
        check("t1_req_valid", 64'(mem_req_valid), 64'd1);
        check("t1_req_write", 64'(mem_req_write), 64'd0);
        check("t1_req_addr", mem_req_addr, 64'h1008);
        check("t1_req_ready_busy", 64'(req_ready), 64'd0);
        tick();
        check("t1_req_dropped", 64'(mem_req_valid), 64'd0);
        tick();
        respond(64'hDEADBEEF_00000001);
        check("t1_dv", 64'(data_valid), 64'd1);
        check("t1_data", read_data, 64'hDEADBEEF_00000001);
        check("t1_hit", 64'(cache_result), 64'd0);
        check("t1_done_ready", 64'(req_ready), 64'd0);
        tick();
        check("t1_dv_pulse", 64'(data_valid), 64'd0);
        check("t1_idle_ready", 64'(req_ready), 64'd1);
        check("t1_rd_count", 64'(rd_hs), 64'd1);

        // 2: load hit, same word via unaligned byte address
        load(64'h100C);
        check("t2_dv", 64'(data_valid), 64'd1);
        check("t2_data", read_data, 64'hDEADBEEF_00000001);
        check("t2_hit", 64'(cache_result), 64'd1);
        check("t2_no_mem", 64'(mem_req_valid), 64'd0);
        tick();
        check("t2_dv_pulse", 64'(data_valid), 64'd0);
        check("t2_rd_count", 64'(rd_hs), 64'd1);

        // 3: store hit merges lane 0
        store(64'h1008, 64'h00000000_000000AA, 8'h01);
        check("t3_req_valid", 64'(mem_req_valid), 64'd1);
        check("t3_req_write", 64'(mem_req_write), 64'd1);
        check("t3_req_addr", mem_req_addr, 64'h1008);
        check("t3_wdata", mem_req_wdata, 64'h00000000_000000AA);
        check("t3_wstrb", 64'(mem_req_wstrb), 64'h01);
        tick();
        respond(64'd0);
        check("t3_wc", 64'(write_complete), 64'd1);
        check("t3_no_dv", 64'(data_valid), 64'd0);
        tick();
        check("t3_wc_pulse", 64'(write_complete), 64'd0);
        load(64'h1008);
        check("t3_hit", 64'(cache_result), 64'd1);
        check("t3_merged", read_data, 64'hDEADBEEF_000000AA);
        tick();

        // 4: store miss does not allocate
        store(64'h2000, 64'h11223344_55667788, 8'hFF);
        tick();
        respond(64'd0);
        check("t4_wc", 64'(write_complete), 64'd1);
        tick();
        load(64'h2000);
        check("t4_miss_req", 64'(mem_req_valid), 64'd1);
        check("t4_miss_addr", mem_req_addr, 64'h2000);
        check("t4_no_dv", 64'(data_valid), 64'd0);
        tick();
        respond(64'h55555555_AAAAAAAA);
        check("t4_dv", 64'(data_valid), 64'd1);
        check("t4_data", read_data, 64'h55555555_AAAAAAAA);
        check("t4_hit", 64'(cache_result), 64'd0);
        tick();
        check("t4_wr_count", 64'(wr_hs), 64'd2);

        // 5: conflicting tag on line 1 under backpressure
        load(64'h1008);
        check("t5_pre_hit", 64'(cache_result), 64'd1);
        tick();
        mem_req_ready = 1'b0;
        load(64'h1088);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t5_stall_valid%0d", i), 64'(mem_req_valid), 64'd1);
            check($sformatf("t5_stall_addr%0d", i), mem_req_addr, 64'h1088);
            tick();
        end
        mem_req_ready = 1'b1;
        tick();
        respond(64'h00000000_0000CAFE);
        check("t5_dv", 64'(data_valid), 64'd1);
        check("t5_data", read_data, 64'h00000000_0000CAFE);
        tick();
        check("t5_read_data_hold", read_data, 64'h00000000_0000CAFE);
        load(64'h1008);
        check("t5_evicted_req", 64'(mem_req_valid), 64'd1);
        check("t5_evicted_addr", mem_req_addr, 64'h1008);
        check("t5_evicted_no_dv", 64'(data_valid), 64'd0);
        tick();
        respond(64'hDEADBEEF_000000AA);
        check("t5_refill_hit", 64'(cache_result), 64'd0);
        tick();
        check("t5_rd_count", 64'(rd_hs), 64'd4);

        // 6: reset while waiting for read data
        load(64'h1088);
        tick();
        reset = 1'b0;
        #1;
        check("t6_async_ready", 64'(req_ready), 64'd1);
        check("t6_async_req", 64'(mem_req_valid), 64'd0);
        check("t6_async_data", read_data, 64'd0);
        tick();
        reset = 1'b1;
        tick();
        respond(64'h12345678_9ABCDEF0);
        check("t6_no_dv", 64'(data_valid), 64'd0);
        check("t6_no_wc", 64'(write_complete), 64'd0);
        check("t6_ready", 64'(req_ready), 64'd1);
        tick();
        check("t6_no_dv_late", 64'(data_valid), 64'd0);
        load(64'h1008);
        check("t6_line_invalid", 64'(mem_req_valid), 64'd1);
        check("t6_no_hit", 64'(data_valid), 64'd0);
        tick();
        respond(64'hDEADBEEF_000000AA);
        check("t6_dv", 64'(data_valid), 64'd1);
        check("t6_miss_flag", 64'(cache_result), 64'd0);
        tick();
        check("t6_rd_count", 64'(rd_hs), 64'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
- Responder side of the memory-stage data-cache interface: accepts one load or store request at a time from the memory stage and returns load data or store completion.
- Direct-mapped, write-through, no-write-allocate cache of 64-bit words.
- Misses and all stores go to the backing memory over a valid/ready request channel with a separate response strobe.
- Sits between the memory stage and the memory-side bus arbiter.

Parameters:
- LINES, 16, number of cache lines, one 64-bit word per line; power of two, at least 2.
- ADDR_W, 64, byte address width.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- address  in  ADDR_W  byte address; bits [2:0] ignored, access is word-aligned.
- write_data  in  64  store data.
- read_enable  in  1  load request.
- write_enable  in  1  store request.
- byte_enable  in  8  store lane mask, bit i = byte i; ignored for loads.
- req_ready  out  1  high when a request can be accepted (IDLE).
- read_data  out  64  load result, valid while data_valid is high.
- data_valid  out  1  one-cycle pulse, load done.
- cache_result  out  1  hit flag for the completing load, valid with data_valid.
- write_complete  out  1  one-cycle pulse, store done.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_write  out  1  1 = write, 0 = read.
- mem_req_addr  out  ADDR_W  word-aligned address, low 3 bits zero.
- mem_req_wdata  out  64  store data.
- mem_req_wstrb  out  8  store lane mask.
- mem_resp_valid  in  1  read data returned, or write acknowledged.
- mem_resp_rdata  in  64  read data.

Behaviour:
- Address split: index = address[3 +: log2(LINES)]; tag = address[ADDR_W-1 : 3+log2(LINES)].
- Storage per line: valid bit, tag, 64-bit data.

Reset:
- Asserting reset (low) immediately clears all valid bits and the FSM returns to IDLE.
- Output reset values: req_ready=1 after reset releases; all other outputs 0, including read_data.
- Reset in the middle of an operation abandons it. No completion pulse is issued, and a later mem_resp_valid for the abandoned request is ignored.

FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE.

IDLE:
- req_ready=1.
- Address, data and mask are latched on acceptance.
- If write_enable=1, the request is a store and goes to WR_REQ. write_enable takes priority when both enables are high.
- Else if read_enable=1 and the line hits (valid and tag match):
  - read_data <= line data, cache_result <= 1, data_valid pulses the next cycle.
  - Go to DONE. Total latency 1 cycle.
- Else if read_enable=1 and the line misses, go to RD_REQ.

RD_REQ:
- mem_req_valid=1, mem_req_write=0, mem_req_addr = latched address with [2:0]=0.
- Hold until mem_req_ready=1, then go to RD_WAIT.

RD_WAIT:
- On mem_resp_valid, fill the line: valid=1, tag, data = mem_resp_rdata.
- read_data <= mem_resp_rdata, cache_result <= 0, data_valid pulses the next cycle. Go to DONE.

WR_REQ:
- mem_req_valid=1, mem_req_write=1, with latched wdata and wstrb.
- Hold until mem_req_ready=1, then go to WR_WAIT.

WR_WAIT:
- On mem_resp_valid, write_complete pulses the next cycle.
- If the line hits, merge write_data into the cached word per byte_enable; a miss leaves the cache unchanged.
- Go to DONE.

DONE:
- One cycle. req_ready=0 and the completion pulse is visible.
- Return to IDLE.
- A new request is therefore accepted no earlier than the cycle after the pulse.

Request rules:
- Enables are ignored while req_ready=0; the requester holds or re-presents them.
- While mem_req_valid=1, mem_req_* must stay stable until the handshake.
- mem_resp_valid outside RD_WAIT and WR_WAIT is ignored.
- mem_req_ready may be high in the same cycle mem_req_valid rises; the handshake then completes that cycle.

Other rules:
- A store with byte_enable=0 still performs the memory transaction and completes; the cached data is unchanged.
- read_data holds its last value between loads.

Test Plan:
1. Cold load miss: reset; load 0x1008; mem_req_ready=1; mem responds 2 cycles later with 0xDEADBEEF_00000001 -> one read request at 0x1008; data_valid pulse with that value; cache_result=0.
2. Load hit: repeat load 0x100C -> no mem request; data_valid the cycle after acceptance with 0xDEADBEEF_00000001; cache_result=1.
3. Store hit merge: store 0x1008, data 0x00000000_000000AA, byte_enable 0x01 -> mem write with wstrb 0x01; write_complete pulse; subsequent load hit returns 0xDEADBEEF_000000AA.
4. Store miss, no allocate: store to 0x2000 -> write_complete pulse; next load 0x2000 misses and issues a mem read.
5. Conflict and backpressure: load 0x1008 then 0x1088 (same index, LINES=16); hold mem_req_ready=0 for 5 cycles -> mem_req_valid and mem_req_addr stable for all 5 cycles; after the fill, load 0x1008 misses again.
6. Reset mid-miss: assert reset in RD_WAIT, then deliver mem_resp_valid after release -> no data_valid; all lines invalid; req_ready=1.
